// File: rtl/bsg_axi_bus_pkg.sv
// bsg_axi_bus_pkg: AXI4 response codes, flat bus widths
// and the address-to-slot decode shared by the AXI4 demux.
package bsg_axi_bus_pkg;

  localparam logic [1:0] axi4_okay_c   = 2'b00;
  localparam logic [1:0] axi4_decerr_c = 2'b11;

  typedef struct packed {
    logic       ok;
    logic [3:0] idx;
  } slot_dec_t;

  function automatic int mosi_width(input int id_w,
                                    input int addr_w,
                                    input int data_w);
    return 2 * (id_w + addr_w + 30) + data_w + data_w / 8 + 4;
  endfunction

  function automatic int miso_width(input int id_w,
                                    input int data_w);
    return 2 * id_w + data_w + 10;
  endfunction

  // ok is clear when the index names no slot or any
  // address bit above the index field is set.
  function automatic slot_dec_t decode(input logic [63:0] addr,
                                       input int lsb,
                                       input int sel_w,
                                       input int slots);
    logic [63:0] sh;
    slot_dec_t   d;
    sh    = addr >> lsb;
    d.idx = sh[3:0] & 4'((1 << sel_w) - 1);
    d.ok  = ({28'd0, d.idx} < 32'(slots))
            && ((sh >> sel_w) == 64'd0);
    return d;
  endfunction

endpackage

// File: rtl/axi4_demux_decerr.sv
// axi4_demux_decerr: internal DECERR target; sinks W beats and
// returns one B, or returns arlen+1 zero R beats with DECERR.
module axi4_demux_decerr
  import bsg_axi_bus_pkg::*;
#(
  parameter int id_width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  aw_start,
  input  logic [id_width_p-1:0] awid,
  input  logic                  wvalid,
  input  logic                  wlast,
  input  logic                  bready,
  output logic                  wready,
  output logic                  bvalid,
  output logic [id_width_p-1:0] bid,
  input  logic                  ar_start,
  input  logic [id_width_p-1:0] arid,
  input  logic [7:0]            arlen,
  input  logic                  rready,
  output logic                  r_busy,
  output logic                  rvalid,
  output logic [id_width_p-1:0] rid,
  output logic                  rlast
);

  typedef enum logic [1:0] {E_IDLE, E_SINK, E_RESP} werr_e;
  typedef enum logic {R_IDLE, R_ERR} rerr_e;

  werr_e w_state_r, w_state_n;
  rerr_e r_state_r, r_state_n;
  logic [7:0] len_r, beat_r;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_state_r <= E_IDLE;
      r_state_r <= R_IDLE;
      bid       <= '0;
      rid       <= '0;
      len_r     <= '0;
      beat_r    <= '0;
    end else begin
      w_state_r <= w_state_n;
      r_state_r <= r_state_n;
      if (aw_start) bid <= awid;
      if (ar_start) begin
        rid    <= arid;
        len_r  <= arlen;
        beat_r <= '0;
      end else if (rvalid && rready) begin
        beat_r <= beat_r + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_n = w_state_r;
    wready    = (w_state_r == E_SINK);
    bvalid    = (w_state_r == E_RESP);
    unique case (w_state_r)
      E_IDLE: if (aw_start) w_state_n = E_SINK;
      E_SINK: if (wvalid && wlast) w_state_n = E_RESP;
      E_RESP: if (bready) w_state_n = E_IDLE;
      default: w_state_n = E_IDLE;
    endcase
  end

  always_comb begin
    r_state_n = r_state_r;
    r_busy    = (r_state_r == R_ERR);
    rvalid    = r_busy;
    rlast     = r_busy && (beat_r == len_r);
    unique case (r_state_r)
      R_IDLE: if (ar_start) r_state_n = R_ERR;
      R_ERR:  if (rready && rlast) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

endmodule

// File: rtl/axi4_demux.sv
// axi4_demux: 1-to-N AXI4 router; slave port in, slot_num_p master
// ports out, steered by addr[slot_sel_lsb_p +: slot_w], DECERR else.
module axi4_demux
  import bsg_axi_bus_pkg::*;
#(
  parameter int slot_num_p        = 4,
  parameter int id_width_p        = 4,
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int slot_sel_lsb_p    = 28,
  parameter int max_outstanding_p = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic [mosi_width(id_width_p, addr_width_p,
                           data_width_p)-1:0] s_axi4_bus_i,
  output logic [miso_width(id_width_p,
                           data_width_p)-1:0] s_axi4_bus_o,
  output logic [slot_num_p-1:0]
               [mosi_width(id_width_p, addr_width_p,
                           data_width_p)-1:0] m_axi4_demux_o,
  input  logic [slot_num_p-1:0]
               [miso_width(id_width_p,
                           data_width_p)-1:0] m_axi4_demux_i
);

  localparam int slot_w = (slot_num_p > 1) ? $clog2(slot_num_p) : 1;
  localparam int cnt_w  = $clog2(max_outstanding_p + 1);

  typedef logic [slot_w-1:0] slot_t;
  typedef logic [cnt_w-1:0]  cnt_t;
  localparam cnt_t max_c = cnt_t'(max_outstanding_p);

  typedef struct packed {
    logic [id_width_p-1:0]     awid;
    logic [addr_width_p-1:0]   awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic [3:0]                awregion;
    logic                      awvalid;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      bready;
    logic [id_width_p-1:0]     arid;
    logic [addr_width_p-1:0]   araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    logic [3:0]                arregion;
    logic                      arvalid;
    logic                      rready;
  } mosi_s;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [id_width_p-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [id_width_p-1:0]   rid;
    logic [data_width_p-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } miso_s;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_ERR} w_state_e;

  mosi_s s_req;
  miso_s s_rsp;
  mosi_s [slot_num_p-1:0] m_req;
  miso_s [slot_num_p-1:0] m_rsp;

  assign s_req          = s_axi4_bus_i;
  assign s_axi4_bus_o   = s_rsp;
  assign m_rsp          = m_axi4_demux_i;
  assign m_axi4_demux_o = m_req;

  w_state_e w_state_r, w_state_n;
  slot_t aw_slot_r, rd_slot_r, aw_idx, ar_idx;
  cnt_t wr_cnt, rd_cnt;
  slot_dec_t aw_dec, ar_dec;
  logic aw_ok, aw_err, aw_hs, b_dec, w_done;
  logic ar_ok, ar_err, ar_hs, r_dec;
  logic err_wready, err_bvalid, err_rvalid, err_rlast, r_busy;
  logic [id_width_p-1:0] err_bid, err_rid;

  assign aw_dec = decode(64'(s_req.awaddr), slot_sel_lsb_p,
                         slot_w, slot_num_p);
  assign ar_dec = decode(64'(s_req.araddr), slot_sel_lsb_p,
                         slot_w, slot_num_p);
  assign aw_idx = slot_t'(aw_dec.idx);
  assign ar_idx = slot_t'(ar_dec.idx);

  assign b_dec = (wr_cnt != '0) && s_req.bready
                 && m_rsp[aw_slot_r].bvalid;
  assign r_dec = (rd_cnt != '0) && s_req.rready
                 && m_rsp[rd_slot_r].rvalid
                 && m_rsp[rd_slot_r].rlast;

  // A completion in the same cycle frees the slot it occupies,
  // so a full counter can still take a new request.
  assign aw_ok = reset_ni && (w_state_r == W_IDLE)
                 && s_req.awvalid && aw_dec.ok
                 && ((wr_cnt < max_c) || b_dec)
                 && ((wr_cnt == '0) || (aw_idx == aw_slot_r));
  assign aw_err = reset_ni && (w_state_r == W_IDLE)
                  && s_req.awvalid && !aw_dec.ok
                  && (wr_cnt == '0);
  assign aw_hs = aw_ok && m_rsp[aw_idx].awready;

  assign ar_ok = reset_ni && !r_busy
                 && s_req.arvalid && ar_dec.ok
                 && ((rd_cnt < max_c) || r_dec)
                 && ((rd_cnt == '0) || (ar_idx == rd_slot_r));
  assign ar_err = reset_ni && !r_busy
                  && s_req.arvalid && !ar_dec.ok
                  && (rd_cnt == '0);
  assign ar_hs = ar_ok && m_rsp[ar_idx].arready;

  assign w_done = (w_state_r == W_DATA) && s_req.wvalid
                  && s_req.wlast && m_rsp[aw_slot_r].wready;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_state_r <= W_IDLE;
      aw_slot_r <= '0;
      rd_slot_r <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      w_state_r <= w_state_n;
      if (aw_hs) aw_slot_r <= aw_idx;
      if (ar_hs) rd_slot_r <= ar_idx;
      if (aw_hs && !b_dec) wr_cnt <= wr_cnt + cnt_t'(1);
      else if (!aw_hs && b_dec) wr_cnt <= wr_cnt - cnt_t'(1);
      if (ar_hs && !r_dec) rd_cnt <= rd_cnt + cnt_t'(1);
      else if (!ar_hs && r_dec) rd_cnt <= rd_cnt - cnt_t'(1);
    end
  end

  always_comb begin
    w_state_n = w_state_r;
    unique case (w_state_r)
      W_IDLE: begin
        if (aw_hs) w_state_n = W_DATA;
        else if (aw_err) w_state_n = W_ERR;
      end
      W_DATA: if (w_done) w_state_n = W_IDLE;
      W_ERR: if (err_bvalid && s_req.bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    m_req = '0;
    for (int i = 0; i < slot_num_p; i++) begin
      m_req[i]          = s_req;
      m_req[i].awregion = '0;
      m_req[i].arregion = '0;
      m_req[i].awvalid  = aw_ok && (aw_idx == slot_t'(i));
      m_req[i].wvalid   = (w_state_r == W_DATA) && s_req.wvalid
                          && (aw_slot_r == slot_t'(i));
      m_req[i].bready   = (wr_cnt != '0) && s_req.bready
                          && (aw_slot_r == slot_t'(i));
      m_req[i].arvalid  = ar_ok && (ar_idx == slot_t'(i));
      m_req[i].rready   = (rd_cnt != '0) && s_req.rready
                          && (rd_slot_r == slot_t'(i));
    end
  end

  // DECERR bursts need empty counters, so error and slot
  // responses never compete for the slave port.
  always_comb begin
    s_rsp         = '0;
    s_rsp.awready = aw_hs || aw_err;
    s_rsp.arready = ar_hs || ar_err;
    if (w_state_r == W_DATA) s_rsp.wready = m_rsp[aw_slot_r].wready;
    else if (w_state_r == W_ERR) s_rsp.wready = err_wready;
    if (err_bvalid) begin
      s_rsp.bvalid = 1'b1;
      s_rsp.bid    = err_bid;
      s_rsp.bresp  = axi4_decerr_c;
    end else if (wr_cnt != '0) begin
      s_rsp.bvalid = m_rsp[aw_slot_r].bvalid;
      s_rsp.bid    = m_rsp[aw_slot_r].bid;
      s_rsp.bresp  = m_rsp[aw_slot_r].bresp;
    end
    if (r_busy) begin
      s_rsp.rvalid = err_rvalid;
      s_rsp.rid    = err_rid;
      s_rsp.rresp  = axi4_decerr_c;
      s_rsp.rlast  = err_rlast;
    end else if (rd_cnt != '0) begin
      s_rsp.rvalid = m_rsp[rd_slot_r].rvalid;
      s_rsp.rid    = m_rsp[rd_slot_r].rid;
      s_rsp.rdata  = m_rsp[rd_slot_r].rdata;
      s_rsp.rresp  = m_rsp[rd_slot_r].rresp;
      s_rsp.rlast  = m_rsp[rd_slot_r].rlast;
    end
  end

  axi4_demux_decerr #(
    .id_width_p(id_width_p)
  ) u_decerr (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .aw_start(aw_err),
    .awid    (s_req.awid),
    .wvalid  (s_req.wvalid),
    .wlast   (s_req.wlast),
    .bready  (s_req.bready),
    .wready  (err_wready),
    .bvalid  (err_bvalid),
    .bid     (err_bid),
    .ar_start(ar_err),
    .arid    (s_req.arid),
    .arlen   (s_req.arlen),
    .rready  (s_req.rready),
    .r_busy  (r_busy),
    .rvalid  (err_rvalid),
    .rid     (err_rid),
    .rlast   (err_rlast)
  );

endmodule

// File: tb/tb_axi4_demux.sv
// tb_axi4_demux: directed scenarios for the 4-slot AXI4 demux
// with hand-computed expectations.
module tb_axi4_demux;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [3:0]  awregion;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        arvalid;
    logic        rready;
  } mosi_s;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } miso_s;

  logic clk, reset_ni;
  mosi_s s_req;
  miso_s s_rsp;
  mosi_s [3:0] m_req;
  miso_s [3:0] m_rsp;
  logic [3:0] awv, wv, arv, brd, rrd;
  int checks, errors;

  axi4_demux #(
    .slot_num_p(4), .id_width_p(4), .addr_width_p(32),
    .data_width_p(32), .slot_sel_lsb_p(28),
    .max_outstanding_p(4)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .s_axi4_bus_i(s_req), .s_axi4_bus_o(s_rsp),
    .m_axi4_demux_o(m_req), .m_axi4_demux_i(m_rsp)
  );

  always #5 clk = ~clk;

  always_comb begin
    awv = '0; wv = '0; arv = '0; brd = '0; rrd = '0;
    for (int i = 0; i < 4; i++) begin
      awv[i] = m_req[i].awvalid;
      wv[i]  = m_req[i].wvalid;
      arv[i] = m_req[i].arvalid;
      brd[i] = m_req[i].bready;
      rrd[i] = m_req[i].rready;
    end
  end

  task automatic test_reset();
    s_req.awvalid = 1; s_req.awaddr = 32'h2000_0000;
    s_req.arvalid = 1; s_req.araddr = 32'h1000_0000;
    s_req.wvalid = 1; s_req.bready = 1; s_req.rready = 1;
    m_rsp[0].bvalid = 1; m_rsp[0].rvalid = 1;
    #1;
    checks++;
    if ({s_rsp.awready, s_rsp.arready, s_rsp.wready,
         s_rsp.bvalid, s_rsp.rvalid} !== 5'b0)
      begin errors++; $display("FAIL reset_s got %b exp 0",
        {s_rsp.awready, s_rsp.arready, s_rsp.wready,
         s_rsp.bvalid, s_rsp.rvalid}); end
    checks++;
    if ({awv, wv, arv, brd, rrd} !== 20'h0)
      begin errors++; $display("FAIL reset_m got %h exp 0",
        {awv, wv, arv, brd, rrd}); end
    checks++;
    if ({dut.wr_cnt, dut.rd_cnt} !== 6'd0)
      begin errors++; $display("FAIL reset_cnt got %h exp 0",
        {dut.wr_cnt, dut.rd_cnt}); end
    s_req = '0;
    m_rsp[0].bvalid = 0; m_rsp[0].rvalid = 0;
    repeat (2) @(negedge clk);
    reset_ni = 1;
  endtask

  task automatic test_write_slot();
    @(negedge clk);
    s_req.wvalid = 1;
    #1; checks++;
    if ({s_rsp.wready, wv} !== 5'b0)
      begin errors++; $display("FAIL w_before_aw got %b exp 0",
        {s_rsp.wready, wv}); end
    @(negedge clk);
    s_req.wvalid = 0; s_req.awvalid = 1;
    s_req.awaddr = 32'h2000_0000; s_req.awlen = 3;
    s_req.awid = 5; s_req.awregion = 4'hf;
    #1; checks++;
    if ({s_rsp.awready, awv} !== 5'b1_0100)
      begin errors++; $display("FAIL aw_steer got %b exp 10100",
        {s_rsp.awready, awv}); end
    checks++;
    if ({m_req[1].awaddr, m_req[2].awregion} !== 36'h2000_0000_0)
      begin errors++; $display("FAIL aw_bcast got %h exp 200000000",
        {m_req[1].awaddr, m_req[2].awregion}); end
    @(negedge clk);
    s_req.awvalid = 0;
    #1; checks++;
    if (dut.wr_cnt !== 3'd1)
      begin errors++; $display("FAIL wr_cnt_inc got %0d exp 1",
        dut.wr_cnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_req.wvalid = 1; s_req.wlast = (k == 3);
      #1; checks++;
      if ({s_rsp.wready, wv} !== 5'b1_0100)
        begin errors++; $display("FAIL w_beat%0d got %b exp 10100",
          k, {s_rsp.wready, wv}); end
    end
    @(negedge clk);
    s_req.wvalid = 0; s_req.wlast = 0; s_req.bready = 1;
    m_rsp[2].bvalid = 1; m_rsp[2].bid = 5; m_rsp[2].bresp = 0;
    m_rsp[1].bvalid = 1; m_rsp[1].bid = 9; m_rsp[1].bresp = 2;
    #1; checks++;
    if ({s_rsp.bvalid, s_rsp.bid, s_rsp.bresp, brd} !== 11'b1_0101_00_0100)
      begin errors++; $display("FAIL b_pass got %b exp 10101000100",
        {s_rsp.bvalid, s_rsp.bid, s_rsp.bresp, brd}); end
    @(negedge clk);
    m_rsp[2].bvalid = 0; m_rsp[1].bvalid = 0; s_req.bready = 0;
    #1; checks++;
    if ({dut.wr_cnt, s_rsp.bvalid} !== 4'd0)
      begin errors++; $display("FAIL wr_cnt_dec got %h exp 0",
        {dut.wr_cnt, s_rsp.bvalid}); end
  endtask

  task automatic test_read_pending();
    @(negedge clk);
    s_req.arvalid = 1; s_req.araddr = 32'h1000_0000;
    s_req.arid = 1; s_req.arlen = 0;
    #1; checks++;
    if ({s_rsp.arready, arv} !== 5'b1_0010)
      begin errors++; $display("FAIL ar1 got %b exp 10010",
        {s_rsp.arready, arv}); end
    @(negedge clk);
    s_req.araddr = 32'h3000_0000; s_req.arid = 2;
    #1; checks++;
    if ({s_rsp.arready, arv} !== 5'b0)
      begin errors++; $display("FAIL ar2_block got %b exp 0",
        {s_rsp.arready, arv}); end
    @(negedge clk);
    s_req.rready = 1; m_rsp[1].rvalid = 1; m_rsp[1].rlast = 1;
    m_rsp[1].rid = 1; m_rsp[1].rdata = 32'hAAAA_5555;
    #1; checks++;
    if ({s_rsp.arready, s_rsp.rvalid, s_rsp.rdata, rrd} !== {2'b01, 32'hAAAA_5555, 4'b0010})
      begin errors++; $display("FAIL r1_pass got %h", {s_rsp.arready,
        s_rsp.rvalid, s_rsp.rdata, rrd}); end
    @(negedge clk);
    m_rsp[1].rvalid = 0; s_req.rready = 0;
    #1; checks++;
    if ({s_rsp.arready, arv} !== 5'b1_1000)
      begin errors++; $display("FAIL ar2_go got %b exp 11000",
        {s_rsp.arready, arv}); end
    @(negedge clk);
    s_req.arvalid = 0; s_req.rready = 1;
    m_rsp[3].rvalid = 1; m_rsp[3].rlast = 1; m_rsp[3].rid = 2;
    #1; checks++;
    if ({s_rsp.rvalid, s_rsp.rid, rrd} !== 9'b1_0010_1000)
      begin errors++; $display("FAIL r3_pass got %b exp 100101000",
        {s_rsp.rvalid, s_rsp.rid, rrd}); end
    @(negedge clk);
    m_rsp[3].rvalid = 0; s_req.rready = 0;
    #1; checks++;
    if (dut.rd_cnt !== 3'd0)
      begin errors++; $display("FAIL rd_cnt got %0d exp 0",
        dut.rd_cnt); end
  endtask

  task automatic test_read_decerr();
    int beats;
    logic exp_last;
    @(negedge clk);
    s_req.arvalid = 1; s_req.araddr = 32'h5000_0000;
    s_req.arid = 3; s_req.arlen = 7;
    #1; checks++;
    if ({s_rsp.arready, arv} !== 5'b1_0000)
      begin errors++; $display("FAIL ar_decerr got %b exp 10000",
        {s_rsp.arready, arv}); end
    beats = 0;
    for (int c = 0; c < 80 && beats < 8; c++) begin
      @(negedge clk);
      s_req.rready = 1'($urandom_range(0, 1));
      s_req.arvalid = (c == 0);
      s_req.araddr = 32'h0;
      #1;
      if (c == 0) begin
        checks++;
        if (s_rsp.arready !== 1'b0)
          begin errors++; $display("FAIL ar_in_rerr got 1 exp 0"); end
      end
      exp_last = (beats == 7);
      checks++;
      if ({s_rsp.rvalid, s_rsp.rid, s_rsp.rresp, s_rsp.rdata,
           s_rsp.rlast} !== {1'b1, 4'd3, 2'b11, 32'd0, exp_last})
        begin errors++; $display("FAIL rerr_beat%0d got %h", beats,
          {s_rsp.rvalid, s_rsp.rid, s_rsp.rresp, s_rsp.rdata,
           s_rsp.rlast}); end
      if (s_rsp.rvalid && s_req.rready) beats++;
    end
    @(negedge clk);
    s_req.rready = 0; s_req.arvalid = 0;
    #1; checks++;
    if ({beats[3:0], s_rsp.rvalid} !== 5'b1000_0)
      begin errors++; $display("FAIL rerr_done got %0d/%b exp 8/0",
        beats, s_rsp.rvalid); end
  endtask

  task automatic test_write_decerr();
    @(negedge clk);
    s_req.awvalid = 1; s_req.awaddr = 32'h4000_0000;
    s_req.awid = 9;
    #1; checks++;
    if ({s_rsp.awready, awv} !== 5'b1_0000)
      begin errors++; $display("FAIL aw_decerr got %b exp 10000",
        {s_rsp.awready, awv}); end
    @(negedge clk);
    #1; checks++;
    if (s_rsp.awready !== 1'b0)
      begin errors++; $display("FAIL aw_in_werr got 1 exp 0"); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_req.awvalid = 0; s_req.wvalid = 1; s_req.wlast = (k == 1);
      #1; checks++;
      if ({s_rsp.wready, wv} !== 5'b1_0000)
        begin errors++; $display("FAIL werr_beat%0d got %b exp 10000",
          k, {s_rsp.wready, wv}); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_req.wvalid = 0; s_req.wlast = 0; s_req.bready = 0;
      #1; checks++;
      if ({s_rsp.bvalid, s_rsp.bresp, s_rsp.bid} !== 7'b1_11_1001)
        begin errors++; $display("FAIL berr_hold%0d got %b exp 1111001",
          k, {s_rsp.bvalid, s_rsp.bresp, s_rsp.bid}); end
    end
    @(negedge clk);
    s_req.bready = 1;
    #1; checks++;
    if (s_rsp.bvalid !== 1'b1)
      begin errors++; $display("FAIL berr_hs got 0 exp 1"); end
    @(negedge clk);
    s_req.bready = 0;
    #1; checks++;
    if (s_rsp.bvalid !== 1'b0)
      begin errors++; $display("FAIL berr_clear got 1 exp 0"); end
  endtask

  task automatic test_outstanding();
    s_req.awaddr = 32'h0000_0100; s_req.awlen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_req.awvalid = 1;
      #1; checks++;
      if ({s_rsp.awready, awv} !== 5'b1_0001)
        begin errors++; $display("FAIL os_aw%0d got %b exp 10001",
          k, {s_rsp.awready, awv}); end
      @(negedge clk);
      s_req.awvalid = 0; s_req.wvalid = 1; s_req.wlast = 1;
      @(negedge clk);
      s_req.wvalid = 0; s_req.wlast = 0;
    end
    @(negedge clk);
    s_req.awvalid = 1;
    #1; checks++;
    if ({dut.wr_cnt, s_rsp.awready, awv} !== 8'b100_0_0000)
      begin errors++; $display("FAIL os_full got %b exp 10000000",
        {dut.wr_cnt, s_rsp.awready, awv}); end
    @(negedge clk);
    m_rsp[0].bvalid = 1; s_req.bready = 1;
    #1; checks++;
    if ({s_rsp.awready, awv} !== 5'b1_0001)
      begin errors++; $display("FAIL os_swap got %b exp 10001",
        {s_rsp.awready, awv}); end
    @(negedge clk);
    s_req.awvalid = 0; m_rsp[0].bvalid = 0; s_req.bready = 0;
    s_req.wvalid = 1; s_req.wlast = 1;
    #1; checks++;
    if (dut.wr_cnt !== 3'd4)
      begin errors++; $display("FAIL os_cnt got %0d exp 4",
        dut.wr_cnt); end
    @(negedge clk);
    s_req.wvalid = 0; s_req.wlast = 0;
    m_rsp[0].bvalid = 1; s_req.bready = 1;
    repeat (4) @(negedge clk);
    m_rsp[0].bvalid = 0; s_req.bready = 0;
    #1; checks++;
    if (dut.wr_cnt !== 3'd0)
      begin errors++; $display("FAIL os_drain got %0d exp 0",
        dut.wr_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s_req.awvalid = 1; s_req.awaddr = 32'h1000_0000; s_req.awlen = 3;
    @(negedge clk);
    s_req.awvalid = 0; s_req.wvalid = 1;
    @(negedge clk);
    #1; checks++;
    if ({s_rsp.wready, wv} !== 5'b1_0010)
      begin errors++; $display("FAIL mid_w got %b exp 10010",
        {s_rsp.wready, wv}); end
    #1 reset_ni = 0;
    s_req.awvalid = 1; s_req.awaddr = 32'h3000_0000; s_req.awlen = 0;
    #1; checks++;
    if ({s_rsp.wready, wv, s_rsp.awready, awv, dut.wr_cnt} !== 13'd0)
      begin errors++; $display("FAIL mid_rst got %b exp 0",
        {s_rsp.wready, wv, s_rsp.awready, awv, dut.wr_cnt}); end
    @(negedge clk);
    reset_ni = 1; s_req.wvalid = 0;
    #1; checks++;
    if ({s_rsp.awready, awv} !== 5'b1_1000)
      begin errors++; $display("FAIL post_aw got %b exp 11000",
        {s_rsp.awready, awv}); end
    @(negedge clk);
    s_req.awvalid = 0; s_req.wvalid = 1; s_req.wlast = 1;
    #1; checks++;
    if ({s_rsp.wready, wv} !== 5'b1_1000)
      begin errors++; $display("FAIL post_w got %b exp 11000",
        {s_rsp.wready, wv}); end
    @(negedge clk);
    s_req.wvalid = 0; s_req.wlast = 0; s_req.bready = 1;
    m_rsp[3].bvalid = 1; m_rsp[3].bid = 7; m_rsp[3].bresp = 0;
    #1; checks++;
    if ({s_rsp.bvalid, s_rsp.bid, brd} !== 9'b1_0111_1000)
      begin errors++; $display("FAIL post_b got %b exp 101111000",
        {s_rsp.bvalid, s_rsp.bid, brd}); end
    @(negedge clk);
    m_rsp[3].bvalid = 0; s_req.bready = 0;
    #1; checks++;
    if (dut.wr_cnt !== 3'd0)
      begin errors++; $display("FAIL post_cnt got %0d exp 0",
        dut.wr_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    clk = 0; reset_ni = 0;
    s_req = '0; m_rsp = '0;
    for (int i = 0; i < 4; i++) begin
      m_rsp[i].awready = 1;
      m_rsp[i].wready  = 1;
      m_rsp[i].arready = 1;
    end
    test_reset();
    test_write_slot();
    test_read_pending();
    test_read_decerr();
    test_write_decerr();
    test_outstanding();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
